// File: rtl/ahb_slave_itfc_gen2.sv
// ahb_slave_itfc_gen2
//   AHB slave front end of the AHB-to-APB bridge. Decodes NUM_SLV equal
//   address windows starting at BASE_ADDR. Flags mapped, active transfers
//   on `valid` and drives a one-hot window select. It also delays
//   Haddr/Hwdata/Hwrite by PIPE_DEPTH clocks for the bridge APB FSM.
//
//   Optional feature macro: ERR_RESP_EN
//     defined   - unmapped active transfers get a two-cycle AHB ERROR
//                 response, and a saturating counter tallies them.
//     undefined - Hresp tied OKAY, Hreadyout tied 1, err_cnt tied 0.
//                 Unmapped transfers are silently dropped.
//
// Ports
//   Hclk, Hreset          clock, asynchronous active-high reset
//   Hwrite, Hreadyin,     AHB request side
//   Htrans, Haddr, Hwdata
//   Hreadyout, Hresp      AHB response side
//   valid, tempselx       combinational decode results for the APB FSM
//   Haddr_p, Hwdata_p,    request fields delayed PIPE_DEPTH clocks
//   Hwrite_p
//   err_cnt               saturating count of unmapped active transfers
module ahb_slave_itfc_gen2 #(
  parameter int                ADDR_W        = 32,
  parameter int                DATA_W        = 32,
  parameter int                NUM_SLV       = 3,
  parameter logic [ADDR_W-1:0] BASE_ADDR     = 32'h8000_0000,
  parameter int                SLV_SIZE_LOG2 = 26,
  parameter int                PIPE_DEPTH    = 2,
  parameter int                CNT_W         = 8
) (
  input  logic               Hclk,
  input  logic               Hreset,
  input  logic               Hwrite,
  input  logic               Hreadyin,
  input  logic [1:0]         Htrans,
  input  logic [ADDR_W-1:0]  Haddr,
  input  logic [DATA_W-1:0]  Hwdata,
  output logic               Hreadyout,
  output logic [1:0]         Hresp,
  output logic               valid,
  output logic [NUM_SLV-1:0] tempselx,
  output logic [ADDR_W-1:0]  Haddr_p,
  output logic [DATA_W-1:0]  Hwdata_p,
  output logic               Hwrite_p,
  output logic [CNT_W-1:0]   err_cnt
);

  // Limit is held one bit wider so a top window ending at 2**ADDR_W
  // does not wrap to zero.
  localparam logic [ADDR_W:0] WIN_SPAN = (ADDR_W+1)'(NUM_SLV) << SLV_SIZE_LOG2;
  localparam logic [ADDR_W:0] LIMIT    = {1'b0, BASE_ADDR} + WIN_SPAN;

  logic              mapped;
  logic              active;
  logic [ADDR_W-1:0] win_idx;

  assign mapped  = ({1'b0, Haddr} >= {1'b0, BASE_ADDR}) && ({1'b0, Haddr} < LIMIT);
  assign active  = Htrans[1];  // NONSEQ (10) or SEQ (11)
  assign valid   = Hreadyin & active & mapped;
  assign win_idx = (Haddr - BASE_ADDR) >> SLV_SIZE_LOG2;

  always_comb begin
    tempselx = '0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      tempselx[i] = mapped && (win_idx == ADDR_W'(i));
    end
  end

  // ---------------------------------------------------------------------
  // Request pipeline: free-running shift register, one stage per clock.
  // ---------------------------------------------------------------------
  logic [ADDR_W-1:0] addr_q  [PIPE_DEPTH];
  logic [DATA_W-1:0] data_q  [PIPE_DEPTH];
  logic              write_q [PIPE_DEPTH];

  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
        addr_q[i]  <= '0;
        data_q[i]  <= '0;
        write_q[i] <= 1'b0;
      end
    end else begin
      addr_q[0]  <= Haddr;
      data_q[0]  <= Hwdata;
      write_q[0] <= Hwrite;
      for (int unsigned i = 1; i < PIPE_DEPTH; i++) begin
        addr_q[i]  <= addr_q[i-1];
        data_q[i]  <= data_q[i-1];
        write_q[i] <= write_q[i-1];
      end
    end
  end

  assign Haddr_p  = addr_q[PIPE_DEPTH-1];
  assign Hwdata_p = data_q[PIPE_DEPTH-1];
  assign Hwrite_p = write_q[PIPE_DEPTH-1];

`ifdef ERR_RESP_EN
  // ---------------------------------------------------------------------
  // Two-cycle ERROR response: ERR1 stalls (HREADYOUT low), ERR2 completes.
  // A new unmapped transfer seen in ERR2 re-enters ERR1 back-to-back.
  // ---------------------------------------------------------------------
  typedef enum logic [1:0] {IDLE, ERR1, ERR2} err_state_t;

  err_state_t state, state_nxt;
  logic       err_hit;

  assign err_hit = Hreadyin & active & ~mapped;

  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = err_hit ? ERR1 : IDLE;
      ERR1:    state_nxt = ERR2;
      ERR2:    state_nxt = err_hit ? ERR1 : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    Hreadyout = (state != ERR1);
    Hresp     = (state == IDLE) ? 2'b00 : 2'b01;
  end

  // Inputs are ignored during ERR1, so only IDLE/ERR2 hits are counted.
  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      err_cnt <= '0;
    end else if (err_hit && (state != ERR1) && (err_cnt != '1)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end
`else
  assign Hreadyout = 1'b1;
  assign Hresp     = 2'b00;
  assign err_cnt   = '0;
`endif

endmodule

// File: tb/tb_ahb_slave_itfc_gen2.sv
module tb_ahb_slave_itfc_gen2;

  localparam int     AW    = 32;
  localparam int     DW    = 32;
  localparam int     NS    = 3;
  localparam int     SL    = 26;
  localparam int     PD    = 2;
  localparam longint BASE  = 64'h8000_0000;
  localparam longint LIMIT = BASE + NS * (64'd1 << SL);
`ifdef ERR_RESP_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          Hclk, Hreset, Hwrite, Hreadyin;
  logic [1:0]    Htrans;
  logic [AW-1:0] Haddr;
  logic [DW-1:0] Hwdata;
  logic          Hreadyout, valid, Hwrite_p;
  logic [1:0]    Hresp;
  logic [NS-1:0] tempselx;
  logic [AW-1:0] Haddr_p;
  logic [DW-1:0] Hwdata_p;
  logic [7:0]    err_cnt;

  // Second instance with a 2-bit counter to exercise saturation.
  logic          s_ready, s_valid, s_write_p;
  logic [1:0]    s_resp;
  logic [NS-1:0] s_sel;
  logic [AW-1:0] s_addr_p;
  logic [DW-1:0] s_data_p;
  logic [1:0]    err_cnt2;

  ahb_slave_itfc_gen2 dut (
    .Hclk(Hclk), .Hreset(Hreset), .Hwrite(Hwrite), .Hreadyin(Hreadyin),
    .Htrans(Htrans), .Haddr(Haddr), .Hwdata(Hwdata),
    .Hreadyout(Hreadyout), .Hresp(Hresp), .valid(valid), .tempselx(tempselx),
    .Haddr_p(Haddr_p), .Hwdata_p(Hwdata_p), .Hwrite_p(Hwrite_p), .err_cnt(err_cnt)
  );

  ahb_slave_itfc_gen2 #(.CNT_W(2)) dut2 (
    .Hclk(Hclk), .Hreset(Hreset), .Hwrite(Hwrite), .Hreadyin(Hreadyin),
    .Htrans(Htrans), .Haddr(Haddr), .Hwdata(Hwdata),
    .Hreadyout(s_ready), .Hresp(s_resp), .valid(s_valid), .tempselx(s_sel),
    .Haddr_p(s_addr_p), .Hwdata_p(s_data_p), .Hwrite_p(s_write_p), .err_cnt(err_cnt2)
  );

  initial begin
    Hclk = 1'b0;
    forever #5 Hclk = ~Hclk;
  end

  // ------------------------------------------------------------------
  // Reference model
  // ------------------------------------------------------------------
  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          write;
  } req_t;

  req_t pipe_q[$];     // front = newest captured request
  int   err_left;      // cycles of ERROR response still to be shown (2, 1 or 0)
  int   ref_cnt, ref_cnt2;
  int   passed, total;

  function automatic bit is_mapped(logic [AW-1:0] a);
    longint x;
    x = longint'(a);
    return (x >= BASE) && (x < LIMIT);
  endfunction

  function automatic logic [NS-1:0] sel_of(logic [AW-1:0] a);
    longint x;
    x = longint'(a);
    if (!is_mapped(a)) return '0;
    return NS'(1 << ((x - BASE) >> SL));
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    err_left = 0;
    ref_cnt  = 0;
    ref_cnt2 = 0;
    pipe_q.delete();
    for (int i = 0; i < PD; i++) pipe_q.push_back('{addr: '0, data: '0, write: 1'b0});
  endtask

  task automatic check_regs();
    check("Hreadyout", Hreadyout, (err_left == 2) ? 1'b0 : 1'b1);
    check("Hresp", Hresp, (err_left != 0) ? 2'b01 : 2'b00);
    check("Haddr_p", Haddr_p, pipe_q[PD-1].addr);
    check("Hwdata_p", Hwdata_p, pipe_q[PD-1].data);
    check("Hwrite_p", Hwrite_p, pipe_q[PD-1].write);
    check("err_cnt", err_cnt, ref_cnt);
    check("err_cnt_w2", err_cnt2, ref_cnt2);
  endtask

  // Called at a falling edge; drives one cycle and advances the model.
  task automatic apply(input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic w, input logic [1:0] t, input logic r);
    bit hit;
    Haddr = a; Hwdata = d; Hwrite = w; Htrans = t; Hreadyin = r;
    #1;
    hit = r && t[1] && !is_mapped(a);
    check("valid", valid, r && t[1] && is_mapped(a));
    check("tempselx", tempselx, sel_of(a));
    @(posedge Hclk);
    if (ERR_EN) begin
      if (err_left != 2 && hit) begin
        if (ref_cnt < 255) ref_cnt++;
        if (ref_cnt2 < 3) ref_cnt2++;
      end
      err_left = (err_left == 2) ? 1 : (hit ? 2 : 0);
    end
    pipe_q.push_front('{addr: a, data: d, write: w});
    void'(pipe_q.pop_back());
    #1;
    check_regs();
    @(negedge Hclk);
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic [1:0]    trans;
    logic          ready;
    logic          exp_valid;
    logic [NS-1:0] exp_sel;
  } vec_t;

  vec_t vecs[11];
  logic [AW-1:0] ra;
  int   pick;

  initial begin
    passed = 0; total = 0;
    vecs[0]  = '{32'h8400_0010, 2'b10, 1'b1, 1'b1, 3'b010};
    vecs[1]  = '{32'h8000_0000, 2'b11, 1'b1, 1'b1, 3'b001};
    vecs[2]  = '{32'h8BFF_FFFC, 2'b10, 1'b1, 1'b1, 3'b100};
    vecs[3]  = '{32'h8C00_0000, 2'b10, 1'b1, 1'b0, 3'b000};
    vecs[4]  = '{32'h7FFF_FFFC, 2'b10, 1'b1, 1'b0, 3'b000};
    vecs[5]  = '{32'h83FF_FFFF, 2'b10, 1'b1, 1'b1, 3'b001};
    vecs[6]  = '{32'h8400_0000, 2'b00, 1'b1, 1'b0, 3'b010};
    vecs[7]  = '{32'h8800_0000, 2'b01, 1'b1, 1'b0, 3'b100};
    vecs[8]  = '{32'h8800_0000, 2'b10, 1'b0, 1'b0, 3'b100};
    vecs[9]  = '{32'h0000_0000, 2'b11, 1'b1, 1'b0, 3'b000};
    vecs[10] = '{32'hFFFF_FFFF, 2'b10, 1'b1, 1'b0, 3'b000};

    // Reset
    Hreset = 1'b1; Hwrite = 1'b0; Hreadyin = 1'b0; Htrans = 2'b00;
    Haddr = '0; Hwdata = '0;
    model_reset();
    repeat (2) @(posedge Hclk);
    #1;
    check("reset", {Hreadyout, Hresp, Haddr_p, Hwdata_p, Hwrite_p, err_cnt},
                   {1'b1, 2'b00, 32'h0, 32'h0, 1'b0, 8'h0});
    @(negedge Hclk);
    Hreset = 1'b0;

    // T1: mapped NONSEQ write, pipeline latency
    apply(32'h8400_0010, 32'hCAFE_0001, 1'b1, 2'b10, 1'b1);
    check("T1 early Haddr_p", Haddr_p, 32'h0);
    apply(32'h0, 32'h0, 1'b0, 2'b00, 1'b1);
    check("T1 Haddr_p", Haddr_p, 32'h8400_0010);
    check("T1 Hwrite_p", Hwrite_p, 1'b1);

    // T2: unmapped read -> ERROR response sequence
    apply(32'h8C00_0000, 32'h0, 1'b0, 2'b10, 1'b1);
    check("T2 cycle1", {Hresp, Hreadyout}, ERR_EN ? 3'b010 : 3'b001);
    apply(32'h0, 32'h0, 1'b0, 2'b00, 1'b1);
    check("T2 cycle2", {Hresp, Hreadyout}, ERR_EN ? 3'b011 : 3'b001);
    apply(32'h0, 32'h0, 1'b0, 2'b00, 1'b1);
    check("T2 cycle3", {Hresp, Hreadyout}, 3'b001);
    check("T2 err_cnt", err_cnt, ERR_EN ? 8'd1 : 8'd0);

    // Decode table (T3 boundaries included)
    for (int i = 0; i < 11; i++) begin
      Haddr = vecs[i].addr; Htrans = vecs[i].trans; Hreadyin = vecs[i].ready;
      #1;
      check($sformatf("vec%0d valid", i), valid, vecs[i].exp_valid);
      check($sformatf("vec%0d sel", i), tempselx, vecs[i].exp_sel);
      apply(vecs[i].addr, $urandom, 1'b0, vecs[i].trans, vecs[i].ready);
      apply(32'h0, 32'h0, 1'b0, 2'b00, 1'b1);
      apply(32'h0, 32'h0, 1'b0, 2'b00, 1'b1);
    end

    // T4: back-to-back unmapped transfers, 2-bit counter saturates
    model_reset();
    Hreset = 1'b1;
    @(negedge Hclk);
    Hreset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      apply(32'h7FFF_FFFC, 32'h0, 1'b0, 2'b10, 1'b1);
      check("T4 Hresp held", Hresp, ERR_EN ? 2'b01 : 2'b00);
    end
    check("T4 err_cnt", err_cnt, ERR_EN ? 8'd5 : 8'd0);
    check("T4 saturated", err_cnt2, ERR_EN ? 2'd3 : 2'd0);
    apply(32'h0, 32'h0, 1'b0, 2'b00, 1'b1);
    apply(32'h0, 32'h0, 1'b0, 2'b00, 1'b1);

    // T5: asynchronous reset while in ERR1
    apply(32'h8000_1234, 32'h55AA_55AA, 1'b1, 2'b10, 1'b1);
    apply(32'h9000_0000, 32'h1, 1'b1, 2'b10, 1'b1);
    check("T5 in ERR1", Hreadyout, ERR_EN ? 1'b0 : 1'b1);
    #2;
    Hreset = 1'b1;
    #1;
    check("T5 Hreadyout", Hreadyout, 1'b1);
    check("T5 Hresp", Hresp, 2'b00);
    check("T5 pipe", {Haddr_p, Hwdata_p, Hwrite_p}, 65'h0);
    check("T5 err_cnt", err_cnt, 8'd0);
    model_reset();
    @(negedge Hclk);
    Hreset = 1'b0;

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      pick = $urandom_range(0, 4);
      case (pick)
        0: ra = 32'(BASE) + 32'($urandom_range(0, 7)) - 32'd4;
        1: ra = 32'(LIMIT) + 32'($urandom_range(0, 7)) - 32'd4;
        2: ra = 32'(BASE) + ((32'($urandom_range(0, NS - 1)) + 32'd1) << SL)
                + 32'($urandom_range(0, 3)) - 32'd2;
        default: ra = $urandom;
      endcase
      apply(ra, $urandom, 1'($urandom), 2'($urandom), ($urandom_range(0, 3) != 0));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
